and_or_select_8: RTL and testbench

Registered 8-bit logic selector for the single-cycle processor datapath. It computes the bitwise AND and the bitwise OR of two operands in parallel. A one-bit select chooses which result is used, and the choice is captured in an output register on each clock edge. It serves as the logic-operation slice beside the adder in the ALU.

---
 rtl/logic_sel_pkg.sv | 9 +
 rtl/mux2_w.sv | 21 ++
 rtl/and_or_select_8.sv | 44 ++++
 tb/tb_and_or_select_8.sv | 139 +++++++++++++
 4 files changed

// File: rtl/logic_sel_pkg.sv
// Shared constants for the ALU logic-operation slice: datapath width and select encoding.
// Pure definitions; no logic, no latency, no flow control.
package logic_sel_pkg;

    localparam int   LOGIC_WIDTH = 8;
    localparam logic SEL_AND     = 1'b0;
    localparam logic SEL_OR      = 1'b1;

endpackage : logic_sel_pkg

// File: rtl/mux2_w.sv
// Parameterised WIDTH-bit 2:1 multiplexer: out = in0 when sel = 0, in1 when sel = 1.
// Purely combinational, zero latency, no backpressure.
module mux2_w
    import logic_sel_pkg::*;
#(
    parameter int WIDTH = LOGIC_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in0;
        if (sel != SEL_AND) begin
            out = in1;
        end
    end

endmodule : mux2_w

// File: rtl/and_or_select_8.sv
// Registered AND/OR selector for the ALU: Z = S ? (A | B) : (A & B), one cycle after sampling.
// Latency 1 cycle, one operation per cycle, no handshake and no stall.
module and_or_select_8
    import logic_sel_pkg::*;
#(
    parameter int WIDTH = LOGIC_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] Z
);

    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;

    assign and_res = A & B;
    assign or_res  = A | B;

    mux2_w #(
        .WIDTH (WIDTH)
    ) u_sel_mux (
        .in0 (and_res),
        .in1 (or_res),
        .sel (S),
        .out (z_d)
    );

    // Reset wins over whatever operation is presented on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

    assign Z = z_q;

endmodule : and_or_select_8

// File: tb/tb_and_or_select_8.sv
// Scoreboard bench for and_or_select_8: driver pushes expected results, monitor pops and checks.
module tb_and_or_select_8;

    logic       CLK;
    logic       RESET;
    logic [7:0] A;
    logic [7:0] B;
    logic       S;
    logic [7:0] Z;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    and_or_select_8 #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .A     (A),
        .B     (B),
        .S     (S),
        .Z     (Z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: each result bit is the AND or OR of the operand bits, reset forces zero.
    function automatic logic [7:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic s, input logic rst);
        logic [7:0] r;
        r = 8'h00;
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                if (s) r[i] = (a[i] + b[i]) != 0;
                else   r[i] = (a[i] + b[i]) == 2;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic rst, input string tag);
        @(negedge CLK);
        A     = a;
        B     = b;
        S     = s;
        RESET = rst;
        exp_q.push_back(ref_model(a, b, s, rst));
        tag_q.push_back(tag);
    endtask

    // Monitor: compare just after each edge, then confirm Z holds until just before the next.
    logic [7:0] last_exp;
    logic       have_last = 1'b0;
    always begin
        @(posedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string      t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (Z !== e) begin
                bad++;
                $display("FAIL %s: Z=%h expected=%h at %0t", t, Z, e, $time);
            end
            last_exp  = e;
            have_last = 1'b1;
        end
        #3;
        if (have_last) begin
            total++;
            if (Z !== last_exp) begin
                bad++;
                $display("FAIL hold_between_edges: Z=%h expected=%h at %0t", Z, last_exp, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d expected=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        A = 8'h00; B = 8'h00; S = 1'b0; RESET = 1'b1;

        drive(8'hFF, 8'hFF, 1'b1, 1'b1, "reset_edge1");
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, "reset_edge2");
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, "reset_release");

        drive(8'd2, 8'd54, 1'b0, 1'b0, "and_2_54");
        drive(8'd2, 8'd7,  1'b0, 1'b0, "and_2_7");
        drive(8'd2, 8'd14, 1'b1, 1'b0, "or_2_14");
        drive(8'd2, 8'd14, 1'b0, 1'b0, "toggle_s_to_and");

        // S flips mid-cycle: Z must not move until the next edge.
        @(posedge CLK);
        #2 S = 1'b1;
        drive(8'd2, 8'd14, 1'b0, 1'b0, "s_glitch_ignored");

        drive(8'hAA, 8'h55, 1'b0, 1'b0, "and_aa_55");
        drive(8'hAA, 8'h55, 1'b1, 1'b0, "or_aa_55");
        drive(8'hFF, 8'h0F, 1'b0, 1'b0, "and_ff_0f");
        drive(8'hFF, 8'h0F, 1'b1, 1'b0, "or_ff_0f");

        drive(8'h3C, 8'hC3, 1'b1, 1'b0, "stream_a");
        drive(8'h81, 8'h18, 1'b0, 1'b0, "stream_b");
        drive(8'hF0, 8'h0F, 1'b1, 1'b1, "reset_midstream");
        drive(8'h5A, 8'h0F, 1'b1, 1'b0, "resume_after_reset");

        // A RESET pulse between edges has no effect.
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 RESET = 1'b0;
        drive(8'hC6, 8'h6C, 1'b0, 1'b0, "reset_pulse_ignored");

        for (int n = 0; n < 1000; n++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0, "random");
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge CLK);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_and_or_select_8
